// File: rtl/claw_pkg.sv
// Shared types and constants for the claw-machine game controller.
package claw_pkg;

  // Game sequencer states, in the order a game walks through them.
  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    DROP,
    GRAB,
    RISE,
    HOME,
    RESULT
  } state_t;

  // Phases of one timer request channel: parked, clearing the timer, counting.
  typedef enum logic [1:0] {
    T_IDLE,
    T_ARM,
    T_RUN
  } tphase_t;

  // Terminal count of the external play/motion timers; Timeout is asserted at this count.
  localparam int TIMER_TERMINAL = 10;

endpackage

// File: rtl/claw_timer_req.sv
// Requester side of one timer: clear pulse, then count enable until the
// timer reports terminal count or the sequencer abandons the phase.
module claw_timer_req
  import claw_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_stop,
  input  logic i_timeout,
  output logic o_clr,
  output logic o_en,
  output logic o_done
);

  tphase_t r_phase;
  logic    r_clr;
  logic    r_en;

  // Timeout only counts while we are enabling the timer; a stale terminal
  // level left over from the previous phase is ignored during the clear cycle.
  assign o_done = r_en & i_timeout;
  assign o_clr  = r_clr;
  assign o_en   = r_en;

  // Arm/run/stop handshake. A new start always wins so the sequencer can re-arm
  // on the very edge a previous phase finishes; the enable drops on the edge
  // that samples Timeout so the timer never counts past terminal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= T_IDLE;
      r_clr   <= 1'b0;
      r_en    <= 1'b0;
    end else if (i_start) begin
      r_phase <= T_ARM;
      r_clr   <= 1'b1;
      r_en    <= 1'b0;
    end else if (i_stop) begin
      r_phase <= T_IDLE;
      r_clr   <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      case (r_phase)
        T_ARM: begin
          r_phase <= T_RUN;
          r_clr   <= 1'b0;
          r_en    <= 1'b1;
        end
        T_RUN: begin
          if (i_timeout) begin
            r_phase <= T_IDLE;
            r_en    <= 1'b0;
          end
        end
        default: begin
          r_phase <= T_IDLE;
          r_clr   <= 1'b0;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/claw_game_ctrl.sv
// Claw-machine game controller: coin credit, joystick play, drop/grab/rise
// claw sequence timed by Timer 2, return home and prize reporting.
module claw_game_ctrl
  import claw_pkg::*;
#(
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 9,
  parameter int POS_W      = 4,
  parameter int X_MAX      = 15,
  parameter int Y_MAX      = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin,
  input  logic                btn_drop,
  input  logic                joy_l,
  input  logic                joy_r,
  input  logic                joy_f,
  input  logic                joy_b,
  input  logic                move_tick,
  input  logic                Timeout1,
  input  logic                Timeout2,
  input  logic                prize_sensor,
  output logic                R_TR,
  output logic                En_T1,
  output logic                R_T2,
  output logic                En_T2,
  output logic [POS_W-1:0]    pos_x,
  output logic [POS_W-1:0]    pos_y,
  output logic                claw_down,
  output logic                claw_close,
  output logic                claw_up,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                prize_win
);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [POS_W-1:0]    r_x;
  logic [POS_W-1:0]    r_y;
  logic                r_down;
  logic                r_close;
  logic                r_up;
  logic                r_busy;
  logic                r_win;

  logic w_credit_nz;
  logic w_leave_idle;
  logic w_done1;
  logic w_done2;
  logic w_start1;
  logic w_stop1;
  logic w_start2;
  logic w_x_inc;
  logic w_x_dec;
  logic w_y_inc;
  logic w_y_dec;

  assign w_credit_nz  = (r_credit != '0);
  assign w_leave_idle = (r_state == IDLE) && w_credit_nz;

  // Timer 1 is armed as play starts and dropped early if the player drops.
  assign w_start1 = w_leave_idle;
  assign w_stop1  = (r_state == PLAY) && btn_drop;

  // Timer 2 is re-armed on entry to each of DROP, GRAB and RISE.
  assign w_start2 = ((r_state == PLAY) && (btn_drop || w_done1)) ||
                    (((r_state == DROP) || (r_state == GRAB)) && w_done2);

  // Opposing joystick directions cancel; the walls clamp instead of wrapping.
  assign w_x_inc = move_tick && joy_r && !joy_l && (r_x != POS_W'(X_MAX));
  assign w_x_dec = move_tick && joy_l && !joy_r && (r_x != '0);
  assign w_y_inc = move_tick && joy_f && !joy_b && (r_y != POS_W'(Y_MAX));
  assign w_y_dec = move_tick && joy_b && !joy_f && (r_y != '0);

  claw_timer_req u_timer1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start1),
    .i_stop    (w_stop1),
    .i_timeout (Timeout1),
    .o_clr     (R_TR),
    .o_en      (En_T1),
    .o_done    (w_done1)
  );

  claw_timer_req u_timer2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start2),
    .i_stop    (1'b0),
    .i_timeout (Timeout2),
    .o_clr     (R_T2),
    .o_en      (En_T2),
    .o_done    (w_done2)
  );

  // Credit bank: a coin arriving in the same cycle a game is paid for cancels
  // the charge, so the count is left alone in that case even at saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit <= '0;
    end else if (coin && !w_leave_idle) begin
      if (r_credit != CREDIT_W'(MAX_CREDIT)) begin
        r_credit <= r_credit + CREDIT_W'(1);
      end
    end else if (!coin && w_leave_idle) begin
      r_credit <= r_credit - CREDIT_W'(1);
    end
  end

  // Game sequencer with registered actuator, position and status outputs.
  // claw_close is held from GRAB until the claw is back home so the prize
  // stays gripped during the rise and the return trip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_down  <= 1'b0;
      r_close <= 1'b0;
      r_up    <= 1'b0;
      r_busy  <= 1'b0;
      r_win   <= 1'b0;
    end else begin
      r_win <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_credit_nz) begin
            r_state <= PLAY;
            r_busy  <= 1'b1;
          end
        end
        PLAY: begin
          if (w_x_inc) begin
            r_x <= r_x + POS_W'(1);
          end else if (w_x_dec) begin
            r_x <= r_x - POS_W'(1);
          end
          if (w_y_inc) begin
            r_y <= r_y + POS_W'(1);
          end else if (w_y_dec) begin
            r_y <= r_y - POS_W'(1);
          end
          if (btn_drop || w_done1) begin
            r_state <= DROP;
            r_down  <= 1'b1;
          end
        end
        DROP: begin
          if (w_done2) begin
            r_state <= GRAB;
            r_down  <= 1'b0;
            r_close <= 1'b1;
          end
        end
        GRAB: begin
          if (w_done2) begin
            r_state <= RISE;
            r_up    <= 1'b1;
          end
        end
        RISE: begin
          if (w_done2) begin
            r_state <= HOME;
            r_up    <= 1'b0;
          end
        end
        HOME: begin
          if ((r_x == '0) && (r_y == '0)) begin
            r_state <= RESULT;
            r_close <= 1'b0;
          end else if (move_tick) begin
            if (r_x != '0) begin
              r_x <= r_x - POS_W'(1);
            end
            if (r_y != '0) begin
              r_y <= r_y - POS_W'(1);
            end
          end
        end
        RESULT: begin
          r_win   <= prize_sensor;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_down  <= 1'b0;
          r_close <= 1'b0;
          r_up    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pos_x      = r_x;
  assign pos_y      = r_y;
  assign claw_down  = r_down;
  assign claw_close = r_close;
  assign claw_up    = r_up;
  assign credit     = r_credit;
  assign busy       = r_busy;
  assign prize_win  = r_win;

endmodule

// File: tb/tb_claw_game_ctrl.sv
// Directed bench for claw_game_ctrl with behavioural models of both timers.
module tb_claw_game_ctrl;
  import claw_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin, btn_drop, joy_l, joy_r, joy_f, joy_b, move_tick, prize_sensor;
  logic       Timeout1, Timeout2;
  logic       R_TR, En_T1, R_T2, En_T2;
  logic [3:0] pos_x, pos_y, credit;
  logic       claw_down, claw_close, claw_up, busy, prize_win;

  int checks   = 0;
  int failures = 0;
  int overlapErr = 0;
  int cnt1, cnt2;
  int term1 = 60;
  int term2 = TIMER_TERMINAL;

  claw_game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .coin(coin), .btn_drop(btn_drop),
    .joy_l(joy_l), .joy_r(joy_r), .joy_f(joy_f), .joy_b(joy_b),
    .move_tick(move_tick), .Timeout1(Timeout1), .Timeout2(Timeout2),
    .prize_sensor(prize_sensor), .R_TR(R_TR), .En_T1(En_T1), .R_T2(R_T2),
    .En_T2(En_T2), .pos_x(pos_x), .pos_y(pos_y), .claw_down(claw_down),
    .claw_close(claw_close), .claw_up(claw_up), .credit(credit),
    .busy(busy), .prize_win(prize_win)
  );

  always #5 clk = ~clk;

  // Timer models: clear on R, count while enabled, hold at terminal.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt1 <= 0;
    else if (R_TR) cnt1 <= 0;
    else if (En_T1 && cnt1 < term1) cnt1 <= cnt1 + 1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt2 <= 0;
    else if (R_T2) cnt2 <= 0;
    else if (En_T2 && cnt2 < term2) cnt2 <= cnt2 + 1;
  end
  assign Timeout1 = (cnt1 == term1);
  assign Timeout2 = (cnt2 == term2);

  // Clear and enable of the same timer must never be high together.
  always @(negedge clk) begin
    if (rst_n && ((R_TR && En_T1) || (R_T2 && En_T2))) overlapErr++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; coin = 0; btn_drop = 0; joy_l = 0; joy_r = 0; joy_f = 0; joy_b = 0;
    move_tick = 0; prize_sensor = 0;
    repeat (3) tick();
    checks++;
    if ({R_TR, En_T1, R_T2, En_T2, claw_down, claw_close, claw_up, busy, prize_win} !== 9'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000000",
               {R_TR, En_T1, R_T2, En_T2, claw_down, claw_close, claw_up, busy, prize_win});
    end
    checks++;
    if (credit !== 4'd0) begin failures++; $display("[TB] FAIL reset_credit: got %0d expected 0", credit); end
    checks++;
    if ({pos_x, pos_y} !== 8'd0) begin failures++; $display("[TB] FAIL reset_pos: got (%0d,%0d) expected (0,0)", pos_x, pos_y); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_no_credit: busy got %b expected 0", busy); end
  endtask

  task automatic test_credit_start;
    coin = 1;
    tick();
    checks++;
    if (credit !== 4'd1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL coin1: credit=%0d busy=%b expected 1/0", credit, busy); end
    tick();
    checks++;
    if (credit !== 4'd1 || busy !== 1'b1) begin failures++; $display("[TB] FAIL coin2_start: credit=%0d busy=%b expected 1/1", credit, busy); end
    checks++;
    if (R_TR !== 1'b1 || En_T1 !== 1'b0) begin failures++; $display("[TB] FAIL t1_arm: R_TR=%b En_T1=%b expected 1/0", R_TR, En_T1); end
    tick();
    coin = 0;
    checks++;
    if (credit !== 4'd2) begin failures++; $display("[TB] FAIL coin3: credit got %0d expected 2", credit); end
    checks++;
    if (R_TR !== 1'b0 || En_T1 !== 1'b1) begin failures++; $display("[TB] FAIL t1_run: R_TR=%b En_T1=%b expected 0/1", R_TR, En_T1); end
  endtask

  task automatic test_move;
    int expX;
    joy_r = 1; move_tick = 1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      expX = (k < 15) ? k : 15;
      checks++;
      if (pos_x !== 4'(expX)) begin failures++; $display("[TB] FAIL move_r_%0d: pos_x got %0d expected %0d", k, pos_x, expX); end
    end
    joy_l = 1;
    repeat (3) tick();
    checks++;
    if (pos_x !== 4'd15) begin failures++; $display("[TB] FAIL move_lr_cancel: pos_x got %0d expected 15", pos_x); end
    joy_l = 0; joy_r = 0; joy_b = 1;
    repeat (2) tick();
    checks++;
    if (pos_y !== 4'd0) begin failures++; $display("[TB] FAIL move_b_clamp: pos_y got %0d expected 0", pos_y); end
    joy_b = 0; joy_l = 1; joy_f = 1;
    repeat (3) tick();
    joy_f = 0;
    repeat (7) tick();
    joy_l = 0; move_tick = 0;
    checks++;
    if (pos_x !== 4'd5 || pos_y !== 4'd3) begin failures++; $display("[TB] FAIL move_to_5_3: got (%0d,%0d) expected (5,3)", pos_x, pos_y); end
    btn_drop = 1;
    tick();
    btn_drop = 0;
    checks++;
    if (claw_down !== 1'b1 || R_T2 !== 1'b1 || En_T2 !== 1'b0 || En_T1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL drop_entry: down=%b R_T2=%b En_T2=%b En_T1=%b expected 1/1/0/0", claw_down, R_T2, En_T2, En_T1);
    end
    term1 = TIMER_TERMINAL;
  endtask

  task automatic test_full_cycle;
    int n, r2;
    prize_sensor = 1;
    n = 0; r2 = 0;
    while (claw_down && n < 100) begin n++; if (R_T2) r2++; tick(); end
    checks++;
    if (n !== 12 || r2 !== 1) begin failures++; $display("[TB] FAIL drop_phase: cycles=%0d rpulses=%0d expected 12/1", n, r2); end
    n = 0; r2 = 0;
    while (claw_close && !claw_up && n < 100) begin n++; if (R_T2) r2++; tick(); end
    checks++;
    if (n !== 12 || r2 !== 1) begin failures++; $display("[TB] FAIL grab_phase: cycles=%0d rpulses=%0d expected 12/1", n, r2); end
    n = 0; r2 = 0;
    while (claw_up && n < 100) begin
      n++; if (R_T2) r2++;
      if (!claw_close) begin failures++; $display("[TB] FAIL rise_close: claw_close got 0 expected 1"); end
      tick();
    end
    checks++;
    if (n !== 12 || r2 !== 1) begin failures++; $display("[TB] FAIL rise_phase: cycles=%0d rpulses=%0d expected 12/1", n, r2); end
    checks++;
    if (claw_close !== 1'b1 || R_T2 !== 1'b0 || En_T2 !== 1'b0) begin
      failures++; $display("[TB] FAIL home_entry: close=%b R_T2=%b En_T2=%b expected 1/0/0", claw_close, R_T2, En_T2);
    end
    move_tick = 1;
    repeat (3) tick();
    checks++;
    if (pos_x !== 4'd2 || pos_y !== 4'd0) begin failures++; $display("[TB] FAIL home_3: got (%0d,%0d) expected (2,0)", pos_x, pos_y); end
    repeat (2) tick();
    move_tick = 0;
    checks++;
    if (pos_x !== 4'd0 || pos_y !== 4'd0) begin failures++; $display("[TB] FAIL home_5: got (%0d,%0d) expected (0,0)", pos_x, pos_y); end
    tick();
    checks++;
    if (claw_close !== 1'b0 || busy !== 1'b1 || prize_win !== 1'b0) begin
      failures++; $display("[TB] FAIL result: close=%b busy=%b win=%b expected 0/1/0", claw_close, busy, prize_win);
    end
    tick();
    prize_sensor = 0;
    checks++;
    if (prize_win !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL win_pulse: win=%b busy=%b expected 1/0", prize_win, busy); end
  endtask

  task automatic test_timeout1;
    int n, both, wins;
    tick();
    checks++;
    if (busy !== 1'b1 || R_TR !== 1'b1 || En_T1 !== 1'b0 || credit !== 4'd1) begin
      failures++; $display("[TB] FAIL auto_start: busy=%b R_TR=%b En_T1=%b credit=%0d expected 1/1/0/1", busy, R_TR, En_T1, credit);
    end
    tick();
    checks++;
    if (R_TR !== 1'b0 || En_T1 !== 1'b1) begin failures++; $display("[TB] FAIL t1_arm_len: R_TR=%b En_T1=%b expected 0/1", R_TR, En_T1); end
    n = 0; both = 0;
    while (En_T1 && n < 100) begin n++; if (Timeout1) both++; tick(); end
    checks++;
    if (n !== 11 || both !== 1) begin failures++; $display("[TB] FAIL t1_run_len: en_cycles=%0d en_with_timeout=%0d expected 11/1", n, both); end
    checks++;
    if (claw_down !== 1'b1 || R_T2 !== 1'b1 || En_T1 !== 1'b0) begin
      failures++; $display("[TB] FAIL t1_timeout_drop: down=%b R_T2=%b En_T1=%b expected 1/1/0", claw_down, R_T2, En_T1);
    end
    n = 0; wins = 0;
    while (busy && n < 300) begin n++; tick(); if (prize_win) wins++; end
    checks++;
    if (busy !== 1'b0 || wins !== 0) begin failures++; $display("[TB] FAIL no_prize_end: busy=%b wins=%0d expected 0/0", busy, wins); end
  endtask

  task automatic test_credit_saturate;
    int n, expC;
    tick();
    checks++;
    if (busy !== 1'b1 || credit !== 4'd0) begin failures++; $display("[TB] FAIL last_credit: busy=%b credit=%0d expected 1/0", busy, credit); end
    coin = 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      expC = (k < 9) ? k : 9;
      checks++;
      if (credit !== 4'(expC)) begin failures++; $display("[TB] FAIL sat_%0d: credit got %0d expected %0d", k, credit, expC); end
    end
    coin = 0;
    n = 0;
    while (busy && n < 300) begin n++; tick(); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL game3_end: busy got %b expected 0", busy); end
    coin = 1;
    tick();
    coin = 0;
    checks++;
    if (busy !== 1'b1 || credit !== 4'd9) begin failures++; $display("[TB] FAIL coin_at_start: busy=%b credit=%0d expected 1/9", busy, credit); end
  endtask

  task automatic test_reset_mid_game;
    int n;
    btn_drop = 1;
    tick();
    btn_drop = 0;
    checks++;
    if (claw_down !== 1'b1 || En_T1 !== 1'b0 || R_TR !== 1'b0) begin
      failures++; $display("[TB] FAIL early_drop: down=%b En_T1=%b R_TR=%b expected 1/0/0", claw_down, En_T1, R_TR);
    end
    n = 0;
    while (!claw_close && n < 100) begin n++; tick(); end
    repeat (3) tick();
    checks++;
    if (claw_close !== 1'b1 || En_T2 !== 1'b1) begin failures++; $display("[TB] FAIL grab_running: close=%b En_T2=%b expected 1/1", claw_close, En_T2); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({R_TR, En_T1, R_T2, En_T2, claw_down, claw_close, claw_up, busy, prize_win} !== 9'b0) begin
      failures++;
      $display("[TB] FAIL async_reset_ctrl: got %b expected 000000000",
               {R_TR, En_T1, R_T2, En_T2, claw_down, claw_close, claw_up, busy, prize_win});
    end
    checks++;
    if (credit !== 4'd0 || pos_x !== 4'd0 || pos_y !== 4'd0) begin
      failures++; $display("[TB] FAIL async_reset_data: credit=%0d pos=(%0d,%0d) expected 0/(0,0)", credit, pos_x, pos_y);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || R_TR !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle: busy=%b R_TR=%b expected 0/0", busy, R_TR); end
  endtask

  initial begin
    test_reset();
    test_credit_start();
    test_move();
    test_full_cycle();
    test_timeout1();
    test_credit_saturate();
    test_reset_mid_game();
    checks++;
    if (overlapErr !== 0) begin failures++; $display("[TB] FAIL clr_en_overlap: got %0d cycles expected 0", overlapErr); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
